// File: rtl/vm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vm_pkg : voicemail command, status and state encodings.    Rev 1.0
// ----------------------------------------------------------------------------
package vm_pkg;

  localparam logic [3:0] VM_NOP        = 4'd0;
  localparam logic [3:0] VM_RECORD     = 4'd1;
  localparam logic [3:0] VM_PLAY       = 4'd2;
  localparam logic [3:0] VM_STOP       = 4'd3;
  localparam logic [3:0] VM_DELETE     = 4'd4;
  localparam logic [3:0] VM_DELETE_ALL = 4'd5;

  localparam logic [3:0] VMS_IDLE      = 4'd0;
  localparam logic [3:0] VMS_RECORDING = 4'd1;
  localparam logic [3:0] VMS_PLAYING   = 4'd2;
  localparam logic [3:0] VMS_DONE      = 4'd3;
  localparam logic [3:0] VMS_FULL      = 4'd4;
  localparam logic [3:0] VMS_EMPTY     = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REC_WAIT  = 3'd1,
    S_REC_WR    = 3'd2,
    S_PLAY_WAIT = 3'd3,
    S_PLAY_RD   = 3'd4,
    S_PLAY_DATA = 3'd5,
    S_FINISH    = 3'd6
  } vm_state_e;

endpackage
`default_nettype wire

// File: rtl/vm_slot_table.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vm_slot_table : per-slot message lengths, free-slot finder, popcount. Rev 1.0
// ----------------------------------------------------------------------------
module vm_slot_table
  import vm_pkg::*;
#(
  parameter int SLOTS  = 4,
  parameter int SLOT_W = 2,
  parameter int LEN_W  = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic              clr_all,
  input  logic [SLOT_W-1:0] rd_slot,
  output logic [LEN_W-1:0]  rd_len,
  output logic              any_free,
  output logic [SLOT_W-1:0] free_slot,
  output logic [SLOT_W:0]   msg_count
);

  localparam int CNT_W = SLOT_W + 1;

  logic [LEN_W-1:0] len_q [SLOTS];
  logic [LEN_W-1:0] len_d [SLOTS];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      len_d[i] = len_q[i];
      if (clr_all) begin
        len_d[i] = '0;
      end else if (wr_en && (wr_slot == SLOT_W'(i))) begin
        len_d[i] = wr_len;
      end
    end
  end

  // Scan high to low so the last hit is the lowest free index.
  always_comb begin
    any_free  = 1'b0;
    free_slot = '0;
    count_d   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (len_q[i] == '0) begin
        any_free  = 1'b1;
        free_slot = SLOT_W'(i);
      end
    end
    for (int i = 0; i < SLOTS; i++) begin
      if (len_q[i] != '0) begin
        count_d = count_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        len_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        len_q[i] <= len_d[i];
      end
      count_q <= count_d;
    end
  end

  assign rd_len    = len_q[rd_slot];
  assign msg_count = count_q;

endmodule
`default_nettype wire

// File: rtl/voicemail_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// voicemail_ctrl : sample-paced record/playback sequencer over a req/gnt memory
// port. Optional VM_SIDETONE_EN mirrors mic samples to the output while recording. Rev 1.0
// ----------------------------------------------------------------------------
module voicemail_ctrl
  import vm_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SLOTS   = 4,
  parameter int MSG_LEN = 4096,
  parameter int ADDR_W  = 14
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_tick,
  input  logic [3:0]               voicemail_command,
  input  logic [$clog2(SLOTS)-1:0] vm_slot,
  output logic [3:0]               voicemail_status,
  input  logic [DATA_W-1:0]        audio_in_data,
  output logic [DATA_W-1:0]        audio_out_data,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_din,
  input  logic                     mem_gnt,
  input  logic [DATA_W-1:0]        mem_dout,
  input  logic                     mem_valid,
  output logic [$clog2(SLOTS):0]   msg_count,
  output logic                     overrun
);

  localparam int SLOT_W = $clog2(SLOTS);
  localparam int OFF_W  = $clog2(MSG_LEN);
  localparam int LEN_W  = OFF_W + 1;
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(MSG_LEN);

  vm_state_e         state_q, state_d;
  logic [3:0]        cmd_prev_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  plen_q, plen_d;
  logic              stop_q, stop_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] aout_q, aout_d;
  logic [3:0]        status_q, status_d;
  logic              overrun_q, overrun_d;

  logic              tbl_wr_en;
  logic [SLOT_W-1:0] tbl_wr_slot;
  logic [LEN_W-1:0]  tbl_wr_len;
  logic              tbl_clr_all;
  logic [LEN_W-1:0]  tbl_rd_len;
  logic              tbl_any_free;
  logic [SLOT_W-1:0] tbl_free_slot;

  logic cmd_new;
  logic stop_cmd;

  vm_slot_table #(
    .SLOTS (SLOTS),
    .SLOT_W(SLOT_W),
    .LEN_W (LEN_W)
  ) u_slot_table (
    .clk      (clk),
    .rst_n    (reset_n),
    .wr_en    (tbl_wr_en),
    .wr_slot  (tbl_wr_slot),
    .wr_len   (tbl_wr_len),
    .clr_all  (tbl_clr_all),
    .rd_slot  (vm_slot),
    .rd_len   (tbl_rd_len),
    .any_free (tbl_any_free),
    .free_slot(tbl_free_slot),
    .msg_count(msg_count)
  );

  assign cmd_new  = (voicemail_command != cmd_prev_q) && (voicemail_command != VM_NOP);
  assign stop_cmd = cmd_new && (voicemail_command == VM_STOP);

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    off_d       = off_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    plen_d      = plen_q;
    stop_d      = stop_q;
    req_d       = req_q;
    we_d        = we_q;
    din_d       = din_q;
    aout_d      = aout_q;
    status_d    = status_q;
    overrun_d   = overrun_q;
    tbl_wr_en   = 1'b0;
    tbl_wr_slot = slot_q;
    tbl_wr_len  = '0;
    tbl_clr_all = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_new) begin
          case (voicemail_command)
            VM_RECORD: begin
              if (tbl_any_free) begin
                slot_d      = tbl_free_slot;
                off_d       = '0;
                len_d       = '0;
                stop_d      = 1'b0;
                tbl_wr_en   = 1'b1;
                tbl_wr_slot = tbl_free_slot;
                status_d    = VMS_RECORDING;
                state_d     = S_REC_WAIT;
              end else begin
                status_d = VMS_FULL;
              end
            end
            VM_PLAY: begin
              if (tbl_rd_len == '0) begin
                status_d = VMS_EMPTY;
              end else begin
                slot_d   = vm_slot;
                off_d    = '0;
                cnt_d    = '0;
                plen_d   = tbl_rd_len;
                stop_d   = 1'b0;
                status_d = VMS_PLAYING;
                state_d  = S_PLAY_WAIT;
              end
            end
            VM_DELETE: begin
              tbl_wr_en   = 1'b1;
              tbl_wr_slot = vm_slot;
              status_d    = VMS_IDLE;
            end
            VM_DELETE_ALL: begin
              tbl_clr_all = 1'b1;
              status_d    = VMS_IDLE;
            end
            default: ;
          endcase
        end
      end
      S_REC_WAIT: begin
        if (stop_cmd) begin
          status_d = VMS_DONE;
          state_d  = S_FINISH;
        end else if (sample_tick) begin
          din_d   = audio_in_data;
          req_d   = 1'b1;
          we_d    = 1'b1;
          state_d = S_REC_WR;
        end
      end
      S_REC_WR: begin
        if (stop_cmd)    stop_d    = 1'b1;
        // No capture path exists here, so any tick is a lost sample.
        if (sample_tick) overrun_d = 1'b1;
        if (mem_gnt) begin
          req_d       = 1'b0;
          we_d        = 1'b0;
          len_d       = len_q + LEN_W'(1);
          off_d       = off_q + OFF_W'(1);
          tbl_wr_en   = 1'b1;
          tbl_wr_slot = slot_q;
          tbl_wr_len  = len_q + LEN_W'(1);
          if ((len_q + LEN_W'(1)) == FULL_LEN) begin
            status_d = VMS_FULL;
            state_d  = S_FINISH;
          end else if (stop_d) begin
            status_d = VMS_DONE;
            state_d  = S_FINISH;
          end else begin
            state_d = S_REC_WAIT;
          end
        end
      end
      S_PLAY_WAIT: begin
        if (stop_cmd) begin
          status_d = VMS_DONE;
          state_d  = S_FINISH;
        end else if (sample_tick) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          state_d = S_PLAY_RD;
        end
      end
      S_PLAY_RD: begin
        if (stop_cmd)    stop_d    = 1'b1;
        if (sample_tick) overrun_d = 1'b1;
        if (mem_gnt) begin
          req_d   = 1'b0;
          state_d = S_PLAY_DATA;
        end
      end
      S_PLAY_DATA: begin
        if (stop_cmd)    stop_d    = 1'b1;
        if (sample_tick) overrun_d = 1'b1;
        if (mem_valid) begin
          if (stop_d) begin
            status_d = VMS_DONE;
            state_d  = S_FINISH;
          end else begin
            aout_d = mem_dout;
            off_d  = off_q + OFF_W'(1);
            cnt_d  = cnt_q + LEN_W'(1);
            if ((cnt_q + LEN_W'(1)) == plen_q) begin
              status_d = VMS_DONE;
              state_d  = S_FINISH;
            end else begin
              state_d = S_PLAY_WAIT;
            end
          end
        end
      end
      S_FINISH: begin
        aout_d  = '0;
        req_d   = 1'b0;
        we_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef VM_SIDETONE_EN
    if (((state_q == S_REC_WAIT) || (state_q == S_REC_WR)) && sample_tick) begin
      aout_d = audio_in_data;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cmd_prev_q <= VM_NOP;
      slot_q     <= '0;
      off_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      plen_q     <= '0;
      stop_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      din_q      <= '0;
      aout_q     <= '0;
      status_q   <= VMS_IDLE;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_prev_q <= voicemail_command;
      slot_q     <= slot_d;
      off_q      <= off_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      plen_q     <= plen_d;
      stop_q     <= stop_d;
      req_q      <= req_d;
      we_q       <= we_d;
      din_q      <= din_d;
      aout_q     <= aout_d;
      status_q   <= status_d;
      overrun_q  <= overrun_d;
    end
  end

  // Slot index forms the upper address bits, so the offset wraps inside the slot.
  assign mem_addr         = ADDR_W'({slot_q, off_q});
  assign mem_req          = req_q;
  assign mem_we           = we_q;
  assign mem_din          = din_q;
  assign audio_out_data   = aout_q;
  assign voicemail_status = status_q;
  assign overrun          = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_voicemail_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_voicemail_ctrl : directed bench for voicemail_ctrl (MSG_LEN = 8). Rev 1.0
// ----------------------------------------------------------------------------
module tb_voicemail_ctrl;
  import vm_pkg::*;

  localparam int DATA_W  = 16;
  localparam int SLOTS   = 4;
  localparam int MSG_LEN = 8;
  localparam int ADDR_W  = 14;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              sample_tick = 1'b0;
  logic [3:0]        voicemail_command = 4'd0;
  logic [1:0]        vm_slot = 2'd0;
  logic [3:0]        voicemail_status;
  logic [DATA_W-1:0] audio_in_data = '0;
  logic [DATA_W-1:0] audio_out_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_gnt = 1'b1;
  logic [DATA_W-1:0] mem_dout = '0;
  logic              mem_valid = 1'b0;
  logic [2:0]        msg_count;
  logic              overrun;

  int n_total = 0;
  int n_pass  = 0;
  int req_cycles = 0;

  logic [DATA_W-1:0] mem [0:63];
  logic [ADDR_W-1:0] wr_addr [$];
  logic [DATA_W-1:0] wr_data [$];
  logic [DATA_W-1:0] aout_q [$];
  logic [DATA_W-1:0] aout_prev = '0;

  voicemail_ctrl #(
    .DATA_W (DATA_W),
    .SLOTS  (SLOTS),
    .MSG_LEN(MSG_LEN),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sample_tick      (sample_tick),
    .voicemail_command(voicemail_command),
    .vm_slot          (vm_slot),
    .voicemail_status (voicemail_status),
    .audio_in_data    (audio_in_data),
    .audio_out_data   (audio_out_data),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_din          (mem_din),
    .mem_gnt          (mem_gnt),
    .mem_dout         (mem_dout),
    .mem_valid        (mem_valid),
    .msg_count        (msg_count),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  // Memory: writes land on gnt, read data is valid the cycle after gnt.
  always @(posedge clk) begin
    mem_valid <= 1'b0;
    if (mem_req) req_cycles++;
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        mem[mem_addr[5:0]] <= mem_din;
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_din);
      end else begin
        mem_valid <= 1'b1;
        mem_dout  <= mem[mem_addr[5:0]];
      end
    end
  end

  always @(negedge clk) begin
    if (audio_out_data !== aout_prev) begin
      if (audio_out_data != '0) aout_q.push_back(audio_out_data);
      aout_prev = audio_out_data;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [3:0] c, input logic [1:0] s);
    @(negedge clk);
    voicemail_command = c;
    vm_slot = s;
    @(negedge clk);
    voicemail_command = VM_NOP;
    @(negedge clk);
  endtask

  task automatic do_tick(input logic [DATA_W-1:0] d, input int gap);
    @(negedge clk);
    audio_in_data = d;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    if (gap > 1) repeat (gap - 1) @(negedge clk);
  endtask

  task automatic wait_status(input logic [3:0] exp, input string name);
    int n = 0;
    while ((voicemail_status !== exp) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (voicemail_status !== exp) $display("FAIL %s: status=%0d expected %0d", name, voicemail_status, exp);
    else n_pass++;
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    aout_q.delete();
    req_cycles = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cycles(3);
    n_total++; if (voicemail_status !== VMS_IDLE) $display("FAIL reset_status: got %0d expected 0", voicemail_status); else n_pass++;
    n_total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %0b expected 0", mem_req); else n_pass++;
    n_total++; if (audio_out_data !== '0) $display("FAIL reset_audio_out: got %h expected 0", audio_out_data); else n_pass++;
    n_total++; if (msg_count !== 3'd0) $display("FAIL reset_msg_count: got %0d expected 0", msg_count); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %0b expected 0", overrun); else n_pass++;
    n_total++; if (mem_addr !== '0) $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr); else n_pass++;
    reset_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_record_play();
    int bad;
    clear_logs();
    send_cmd(VM_RECORD, 2'd0);
    n_total++; if (voicemail_status !== VMS_RECORDING) $display("FAIL rp_recording: got %0d expected 1", voicemail_status); else n_pass++;
    for (int i = 1; i <= 5; i++) do_tick(DATA_W'(i * 17), 3);
    send_cmd(VM_STOP, 2'd0);
    wait_status(VMS_DONE, "rp_rec_done");
    cycles(2);
    n_total++; if (wr_addr.size() != 5) $display("FAIL rp_write_count: got %0d expected 5", wr_addr.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if ((wr_addr[i] != ADDR_W'(i)) || (wr_data[i] != DATA_W'((i + 1) * 17))) bad++;
    n_total++; if (bad != 0) $display("FAIL rp_write_data: got %0d bad writes expected 0", bad); else n_pass++;
    n_total++; if (msg_count !== 3'd1) $display("FAIL rp_msg_count: got %0d expected 1", msg_count); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL rp_overrun: got %0b expected 0", overrun); else n_pass++;
    aout_q.delete();
    send_cmd(VM_PLAY, 2'd0);
    n_total++; if (voicemail_status !== VMS_PLAYING) $display("FAIL rp_playing: got %0d expected 2", voicemail_status); else n_pass++;
    for (int i = 0; i < 5; i++) do_tick('0, 3);
    wait_status(VMS_DONE, "rp_play_done");
    cycles(2);
    n_total++; if (aout_q.size() != 5) $display("FAIL rp_play_count: got %0d expected 5", aout_q.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < aout_q.size(); i++)
      if (aout_q[i] != DATA_W'((i + 1) * 17)) bad++;
    n_total++; if (bad != 0) $display("FAIL rp_play_data: got %0d bad samples expected 0", bad); else n_pass++;
    n_total++; if (audio_out_data !== '0) $display("FAIL rp_out_zero: got %h expected 0", audio_out_data); else n_pass++;
  endtask

  task automatic test_slot_full();
    int bad;
    send_cmd(VM_DELETE_ALL, 2'd0);
    cycles(2);
    n_total++; if (msg_count !== 3'd0) $display("FAIL sf_delete_all: got %0d expected 0", msg_count); else n_pass++;
    n_total++; if (voicemail_status !== VMS_IDLE) $display("FAIL sf_del_status: got %0d expected 0", voicemail_status); else n_pass++;
    clear_logs();
    send_cmd(VM_RECORD, 2'd0);
    for (int i = 0; i < 10; i++) do_tick(DATA_W'(16'h0100 + i), 3);
    wait_status(VMS_FULL, "sf_full");
    cycles(2);
    n_total++; if (wr_addr.size() != 8) $display("FAIL sf_write_count: got %0d expected 8", wr_addr.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if ((wr_addr[i] != ADDR_W'(i)) || (wr_data[i] != DATA_W'(16'h0100 + i))) bad++;
    n_total++; if (bad != 0) $display("FAIL sf_write_addr: got %0d bad writes expected 0", bad); else n_pass++;
    n_total++; if (mem_req !== 1'b0) $display("FAIL sf_req_idle: got %0b expected 0", mem_req); else n_pass++;
    n_total++; if (msg_count !== 3'd1) $display("FAIL sf_msg_count: got %0d expected 1", msg_count); else n_pass++;
  endtask

  task automatic test_all_full();
    for (int s = 1; s < 4; s++) begin
      send_cmd(VM_RECORD, 2'd0);
      for (int i = 0; i < 8; i++) do_tick(DATA_W'(s * 256 + i), 3);
      wait_status(VMS_FULL, "af_fill");
      cycles(2);
    end
    n_total++; if (msg_count !== 3'd4) $display("FAIL af_count4: got %0d expected 4", msg_count); else n_pass++;
    clear_logs();
    send_cmd(VM_RECORD, 2'd0);
    cycles(3);
    n_total++; if (voicemail_status !== VMS_FULL) $display("FAIL af_status_full: got %0d expected 4", voicemail_status); else n_pass++;
    n_total++; if (req_cycles != 0) $display("FAIL af_no_req: got %0d req cycles expected 0", req_cycles); else n_pass++;
    n_total++; if (msg_count !== 3'd4) $display("FAIL af_count_still4: got %0d expected 4", msg_count); else n_pass++;
    send_cmd(VM_DELETE, 2'd2);
    cycles(2);
    n_total++; if (voicemail_status !== VMS_IDLE) $display("FAIL af_del_status: got %0d expected 0", voicemail_status); else n_pass++;
    n_total++; if (msg_count !== 3'd3) $display("FAIL af_count3: got %0d expected 3", msg_count); else n_pass++;
    clear_logs();
    send_cmd(VM_RECORD, 2'd0);
    do_tick(16'hBEEF, 3);
    n_total++; if ((wr_addr.size() != 1) || (wr_addr[0] != ADDR_W'(16))) $display("FAIL af_slot2_addr: got %0d writes first %0d expected 1 write at 16", wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : '0); else n_pass++;
    send_cmd(VM_STOP, 2'd0);
    wait_status(VMS_DONE, "af_stop");
    cycles(2);
    n_total++; if (msg_count !== 3'd4) $display("FAIL af_count_refill: got %0d expected 4", msg_count); else n_pass++;
  endtask

  task automatic test_backpressure();
    send_cmd(VM_DELETE_ALL, 2'd0);
    cycles(2);
    clear_logs();
    send_cmd(VM_RECORD, 2'd0);
    mem_gnt = 1'b0;
    do_tick(16'hAAAA, 2);
    do_tick(16'hBBBB, 2);
    n_total++; if (mem_req !== 1'b1) $display("FAIL bp_req_held: got %0b expected 1", mem_req); else n_pass++;
    n_total++; if (wr_addr.size() != 0) $display("FAIL bp_no_write: got %0d expected 0", wr_addr.size()); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL bp_overrun: got %0b expected 1", overrun); else n_pass++;
    mem_gnt = 1'b1;
    cycles(2);
    n_total++; if ((wr_data.size() != 1) || (wr_data[0] != 16'hAAAA)) $display("FAIL bp_one_write: got %0d writes first %h expected 1 of aaaa", wr_data.size(), (wr_data.size() > 0) ? wr_data[0] : '0); else n_pass++;
    send_cmd(VM_STOP, 2'd0);
    wait_status(VMS_DONE, "bp_stop");
    cycles(2);
    n_total++; if (msg_count !== 3'd1) $display("FAIL bp_msg_count: got %0d expected 1", msg_count); else n_pass++;
    aout_q.delete();
    send_cmd(VM_PLAY, 2'd0);
    do_tick('0, 3);
    wait_status(VMS_DONE, "bp_play_done");
    cycles(2);
    n_total++; if ((aout_q.size() != 1) || (aout_q[0] != 16'hAAAA)) $display("FAIL bp_len_one: got %0d samples first %h expected 1 of aaaa", aout_q.size(), (aout_q.size() > 0) ? aout_q[0] : '0); else n_pass++;
  endtask

  task automatic test_edge_cases();
    send_cmd(VM_DELETE_ALL, 2'd0);
    cycles(2);
    clear_logs();
    send_cmd(VM_PLAY, 2'd1);
    cycles(1);
    n_total++; if (voicemail_status !== VMS_EMPTY) $display("FAIL ec_empty_status: got %0d expected 5", voicemail_status); else n_pass++;
    n_total++; if (req_cycles != 0) $display("FAIL ec_empty_no_req: got %0d req cycles expected 0", req_cycles); else n_pass++;
    clear_logs();
    @(negedge clk);
    voicemail_command = VM_RECORD;
    for (int i = 0; i < 8; i++) do_tick(DATA_W'(16'h0200 + i), 1);
    cycles(4);
    voicemail_command = VM_NOP;
    wait_status(VMS_FULL, "ec_hold_full");
    cycles(2);
    n_total++; if (msg_count !== 3'd1) $display("FAIL ec_hold_count: got %0d expected 1", msg_count); else n_pass++;
    n_total++; if (wr_addr.size() != 8) $display("FAIL ec_hold_writes: got %0d expected 8", wr_addr.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_play();
    send_cmd(VM_PLAY, 2'd0);
    n_total++; if (voicemail_status !== VMS_PLAYING) $display("FAIL rm_playing: got %0d expected 2", voicemail_status); else n_pass++;
    mem_gnt = 1'b0;
    do_tick('0, 2);
    n_total++; if (mem_req !== 1'b1) $display("FAIL rm_req_pending: got %0b expected 1", mem_req); else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_total++; if (mem_req !== 1'b0) $display("FAIL rm_req_async: got %0b expected 0", mem_req); else n_pass++;
    n_total++; if (voicemail_status !== VMS_IDLE) $display("FAIL rm_status_async: got %0d expected 0", voicemail_status); else n_pass++;
    n_total++; if (audio_out_data !== '0) $display("FAIL rm_out_async: got %h expected 0", audio_out_data); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL rm_overrun_clr: got %0b expected 0", overrun); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    mem_gnt = 1'b1;
    cycles(2);
    n_total++; if (msg_count !== 3'd0) $display("FAIL rm_count_clr: got %0d expected 0", msg_count); else n_pass++;
    send_cmd(VM_PLAY, 2'd0);
    n_total++; if (voicemail_status !== VMS_EMPTY) $display("FAIL rm_len_clr: got %0d expected 5", voicemail_status); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_record_play();
    test_slot_full();
    test_all_full();
    test_backpressure();
    test_edge_cases();
    test_reset_mid_play();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire
